// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - Request/result bundle for the iterative multiply/divide unit
interface mul_div_unit_if;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        WriteHI;
   logic        WriteLO;
   logic [31:0] WriteData;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, Op, A, B, WriteHI, WriteLO, WriteData,
      input  Busy, Done, DivByZero, HI, LO
   );

   modport slave (
      input  Start, Op, A, B, WriteHI, WriteLO, WriteData,
      output Busy, Done, DivByZero, HI, LO
   );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - 32-cycle shift-add multiplier / restoring divider with HI/LO
module mul_div_unit (
   input  logic          Clk,
   input  logic          Reset,
   mul_div_unit_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // MUL: [63:32] partial product, [31:0] multiplier shifting out.
   // DIV: [63:32] partial remainder, [31:0] dividend shifting out / quotient in.
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_mag_q, b_mag_d;
   logic        negp_q, negp_d;   // product / quotient is negative
   logic        negr_q, negr_d;   // remainder is negative
   logic        dbz_q, dbz_d;     // current division has a zero divisor
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dbzo_q, dbzo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        start_dbz;
   logic        last_iter;
   logic [32:0] mul_sum;
   logic [32:0] div_trial;
   logic [32:0] div_diff;
   logic [63:0] prod;

   assign is_signed = ~bus.Op[0];
   assign a_neg     = is_signed & bus.A[31];
   assign b_neg     = is_signed & bus.B[31];
   assign a_mag     = a_neg ? (32'd0 - bus.A) : bus.A;
   assign b_mag     = b_neg ? (32'd0 - bus.B) : bus.B;
   assign start_dbz = bus.Op[1] & (bus.B == 32'd0);
   assign last_iter = (cnt_q == 5'd31);

   assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag_q} : 33'd0);
   assign div_trial = acc_q[63:31];
   assign div_diff  = div_trial - {1'b0, b_mag_q};

   // Next-state, datapath step, result load and MTHI/MTLO writes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_mag_d = b_mag_q;
      negp_d  = negp_q;
      negr_d  = negr_q;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      prod    = 64'd0;

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               cnt_d   = 5'd0;
               state_d = bus.Op[1] ? S_DIV : S_MUL;
               if (start_dbz) begin
                  // Unsigned divide of the raw dividend by zero naturally
                  // yields quotient all-ones and remainder equal to A.
                  acc_d   = {32'd0, bus.A};
                  b_mag_d = 32'd0;
                  negp_d  = 1'b0;
                  negr_d  = 1'b0;
                  dbz_d   = 1'b1;
               end else begin
                  acc_d   = {32'd0, a_mag};
                  b_mag_d = b_mag;
                  negp_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
                  dbz_d   = 1'b0;
               end
            end
         end
         S_MUL: begin
            acc_d = {mul_sum, acc_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (last_iter) begin
               state_d = S_DONE;
               prod    = negp_q ? (64'd0 - acc_d) : acc_d;
               hi_d    = prod[63:32];
               lo_d    = prod[31:0];
            end
         end
         S_DIV: begin
            if (div_diff[32]) begin
               acc_d = {div_trial[31:0], acc_q[30:0], 1'b0};
            end else begin
               acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            end
            cnt_d = cnt_q + 5'd1;
            if (last_iter) begin
               state_d = S_DONE;
               lo_d    = negp_q ? (32'd0 - acc_d[31:0])  : acc_d[31:0];
               hi_d    = negr_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Register writes only outside the iterative states; a DONE-cycle
      // write lands after the result load and therefore wins.
      if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
         if (bus.WriteHI) hi_d = bus.WriteData;
         if (bus.WriteLO) lo_d = bus.WriteData;
      end

      busy_d = (state_d == S_MUL) || (state_d == S_DIV);
      done_d = (state_d == S_DONE);
      dbzo_d = (state_d == S_DONE) && dbz_d;
   end

   // State, datapath and output registers with asynchronous clear
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         b_mag_q <= 32'd0;
         negp_q  <= 1'b0;
         negr_q  <= 1'b0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbzo_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_mag_q <= b_mag_d;
         negp_q  <= negp_d;
         negr_q  <= negr_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbzo_q  <= dbzo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.DivByZero = dbzo_q;
   assign bus.HI        = hi_q;
   assign bus.LO        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - Scoreboard bench for mul_div_unit
module tb_mul_div_unit;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic Clk;
   logic Reset;
   int   checks;
   int   errors;
   exp_t sb[$];

   mul_div_unit_if bus ();

   mul_div_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural rules
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa;
      longint      sb_v;
      logic [63:0] p;
      logic [63:0] r;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.dbz = 1'b0;
      case (op)
         2'b00: begin p = sa * sb_v; e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b01: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
            end else if (op == 2'b10) begin
               p = sa / sb_v; r = sa % sb_v; e.lo = p[31:0]; e.hi = r[31:0];
            end else begin
               p = {32'd0, a} / {32'd0, b}; r = {32'd0, a} % {32'd0, b};
               e.lo = p[31:0]; e.hi = r[31:0];
            end
         end
      endcase
      return e;
   endfunction

   function automatic logic [31:0] pick();
      int s = $urandom_range(0, 7);
      case (s)
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom();
      endcase
   endfunction

   // Monitor: every Done pulse is matched against the oldest expectation
   always @(negedge Clk) begin
      if (Reset && bus.Done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_hi", bus.HI, e.hi);
            check("result_lo", bus.LO, e.lo);
            check("result_dbz", {31'd0, bus.DivByZero}, {31'd0, e.dbz});
         end
      end
   end

   // mode: 0 plain, 1 Start+WriteLO at edge 10, 2 WriteHI in DONE, 3 WriteLO with Start
   // Entered and left just after a rising edge.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
      int          cyc;
      int          nb;
      logic [31:0] lo_before;
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.A     = a;
      bus.B     = b;
      if (mode == 3) begin
         bus.WriteLO   = 1'b1;
         bus.WriteData = 32'h12345678;
      end
      sb.push_back(model(op, a, b));
      @(posedge Clk); #1;
      bus.Start   = 1'b0;
      bus.WriteLO = 1'b0;
      if (mode == 3) check("write_with_start_lo", bus.LO, 32'h12345678);
      cyc = 0;
      nb  = 0;
      lo_before = 32'd0;
      while (!bus.Done && cyc < 40) begin
         if (bus.Busy) nb++;
         if (mode == 1 && cyc == 9) begin
            lo_before     = bus.LO;
            bus.Start     = 1'b1;
            bus.Op        = 2'b11;
            bus.A         = 32'd1000;
            bus.B         = 32'd3;
            bus.WriteLO   = 1'b1;
            bus.WriteData = 32'hDEADBEEF;
         end
         @(posedge Clk); #1;
         cyc++;
         if (mode == 1 && cyc == 10) begin
            bus.Start   = 1'b0;
            bus.WriteLO = 1'b0;
            check("busy_write_ignored_lo", bus.LO, lo_before);
         end
      end
      check("done_latency", cyc, 32);
      check("busy_cycles", nb, 32);
      if (mode == 2) begin
         bus.WriteHI   = 1'b1;
         bus.WriteData = 32'hCAFEF00D;
      end
      @(posedge Clk); #1;
      bus.WriteHI = 1'b0;
      check("after_done_flags", {29'd0, bus.Busy, bus.Done, bus.DivByZero}, 32'd0);
      if (mode == 2) check("done_cycle_write_hi", bus.HI, 32'hCAFEF00D);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      Reset         = 1'b0;
      bus.Start     = 1'b0;
      bus.Op        = 2'b00;
      bus.A         = 32'd0;
      bus.B         = 32'd0;
      bus.WriteHI   = 1'b0;
      bus.WriteLO   = 1'b0;
      bus.WriteData = 32'd0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_flags", {29'd0, bus.Busy, bus.Done, bus.DivByZero}, 32'd0);
      check("reset_hi", bus.HI, 32'd0);
      check("reset_lo", bus.LO, 32'd0);
      Reset = 1'b1;

      // MTHI / MTLO in IDLE
      bus.WriteHI = 1'b1; bus.WriteLO = 1'b1; bus.WriteData = 32'hA5A5_0F0F;
      @(posedge Clk); #1;
      bus.WriteHI = 1'b0; bus.WriteLO = 1'b0;
      check("mthi_idle", bus.HI, 32'hA5A5_0F0F);
      check("mtlo_idle", bus.LO, 32'hA5A5_0F0F);

      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_op(2'b00, 32'hFFFFFFFD, 32'd5, 0);
      run_op(2'b00, 32'h80000000, 32'h80000000, 0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(2'b11, 32'd100, 32'd0, 0);
      run_op(2'b10, 32'hFFFFFF9C, 32'd0, 2);
      run_op(2'b00, 32'd7, 32'hFFFFFFFE, 3);

      for (int i = 0; i < 24; i++) begin
         run_op(2'($urandom_range(0, 3)), pick(), pick(), 0);
      end

      run_op(2'b01, 32'd6, 32'd7, 1);

      // Asynchronous reset mid-operation
      bus.Start = 1'b1; bus.Op = 2'b11; bus.A = 32'd1000; bus.B = 32'd7;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      repeat (15) @(posedge Clk);
      #1;
      check("busy_before_reset", {31'd0, bus.Busy}, 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      check("reset_mid_flags", {29'd0, bus.Busy, bus.Done, bus.DivByZero}, 32'd0);
      check("reset_mid_hi", bus.HI, 32'd0);
      check("reset_mid_lo", bus.LO, 32'd0);
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b1;
      run_op(2'b01, 32'd2, 32'd3, 0);

      repeat (40) @(posedge Clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL provide these ports, listed as name, direction, width, meaning:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous active-low reset; 0 = reset.
- Start  input  1  request a new operation; sampled only in IDLE.
- Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  32  multiplicand or dividend (rs).
- B  input  32  multiplier or divisor (rt).
- WriteHI  input  1  MTHI strobe.
- WriteLO  input  1  MTLO strobe.
- WriteData  input  32  MTHI/MTLO data.
- Busy  output  1  operation in progress; the EX stage stalls on it.
- Done  output  1  one-cycle completion pulse.
- DivByZero  output  1  divide-by-zero flag, qualified by Done.
- HI  output  32  HI register; product[63:32] or remainder.
- LO  output  32  LO register; product[31:0] or quotient.

Function
REQ-003 SHALL use states IDLE, MUL, DIV, DONE plus a 5-bit iteration counter.
REQ-004 SHALL handle Start=1 in IDLE as follows:
- Latch operand magnitudes, result signs and Op.
- Clear the counter.
- Go to MUL when Op[1]=0, otherwise DIV.
REQ-005 SHALL ignore Start in MUL, DIV and DONE; operands are not re-sampled.
REQ-006 SHALL run MUL as shift-add, one bit per cycle, on 32-bit unsigned magnitudes.
REQ-007 SHALL run DIV as restoring division, one quotient bit per cycle, on unsigned magnitudes.
REQ-008 SHALL spend exactly 32 cycles in MUL/DIV, then enter DONE, loading HI/LO on that same edge.
REQ-009 SHALL return from DONE to IDLE after exactly one cycle.
REQ-010 SHALL meet this timing, counting the Start-sampling edge as edge 0:
- Busy=1 from edge 1 through edge 32.
- Done=1 from edge 33 to edge 34.
- HI/LO are valid from edge 33.
REQ-011 SHALL drive Busy=1 exactly when the state is MUL or DIV, and Done=1 exactly when the state is DONE; both are registered decodes.
REQ-012 SHALL apply signed rules:
- MULT: 64-bit two's-complement product, negated when sign(A) XOR sign(B).
- DIV: quotient truncates toward zero with sign sign(A) XOR sign(B); remainder takes sign(A).
REQ-013 SHALL wrap results modulo 2^32, with no trap, in these cases:
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- MULT 0x80000000 * 0x80000000 gives HI=0x40000000, LO=0.
REQ-014 SHALL handle B=0 in DIV or DIVU as follows:
- Full 32-cycle latency is kept.
- LO=0xFFFFFFFF and HI=A (unmodified input).
- DivByZero=1 for the Done cycle only.
REQ-015 SHALL apply WriteHI/WriteLO on the next edge when in IDLE or DONE, and ignore them in MUL/DIV.
REQ-016 SHALL resolve simultaneous events as follows:
- WriteHI/WriteLO together with Start in IDLE: both the write and the start take effect; the later result overwrites.
- A write in the DONE cycle lands one edge after the result load and wins.
REQ-017 SHALL hold HI/LO stable at all times except on the result load and MTHI/MTLO writes.

Reset
REQ-018 SHALL, while Reset=0, asynchronously force these values regardless of Clk:
- state=IDLE, counter=0.
- Busy=0, Done=0, DivByZero=0.
- HI=0, LO=0, internal operand/accumulator registers=0.
REQ-019 SHALL abort any in-flight operation on reset mid-operation, with no Done pulse.
REQ-020 SHALL accept Start on the first rising edge after Reset returns to 1.

Verification
REQ-021 Bench SHALL run MULTU 0xFFFFFFFF*0xFFFFFFFF -> Busy high 32 cycles, Done at edge 33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-022 Bench SHALL run MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; and MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
REQ-023 Bench SHALL run DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-024 Bench SHALL run DIVU 100/0 -> Done at edge 33 with DivByZero=1, LO=0xFFFFFFFF, HI=0x00000064; DivByZero=0 on the next cycle.
REQ-025 Bench SHALL pulse Start with new operands and WriteLO=1 at edge 10 of a busy MULTU 6*7 -> both ignored; result HI=0, LO=42.
REQ-026 Bench SHALL drive Reset=0 mid-clock at edge 15 of a DIVU -> Busy, HI, LO go 0 immediately with no Done; after release, MULTU 2*3 gives LO=6 at edge 33.
